// File: rtl/simon_pkg.sv
// Shared types and sizes for the Simon game blocks.
package simon_pkg;

  localparam int unsigned NUM_KEYS  = 4;
  localparam int unsigned MAX_LEVEL = 9;
  localparam int unsigned LED_WIDTH = 10;
  localparam int unsigned IDX_W     = 2;
  localparam int unsigned CNT_W     = 4;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_PRESS,
    WAIT_RELEASE,
    PASS,
    FAIL
  } state_t;

endpackage

// File: rtl/encoder_4_2.sv
// One-hot to index encoder, the inverse of decoder_2_4.
//   onehot : key pattern, one bit per LED
//   index  : position of the set bit (0 when not one-hot)
//   valid  : high when exactly one bit is set
module encoder_4_2
  import simon_pkg::*;
(
  input  logic [NUM_KEYS-1:0] onehot,
  output logic [IDX_W-1:0]    index,
  output logic                valid
);

  always_comb begin
    index = '0;
    valid = 1'b0;
    case (onehot)
      4'b0001: begin index = 2'd0; valid = 1'b1; end
      4'b0010: begin index = 2'd1; valid = 1'b1; end
      4'b0100: begin index = 2'd2; valid = 1'b1; end
      4'b1000: begin index = 2'd3; valid = 1'b1; end
      default: begin index = '0;   valid = 1'b0; end
    endcase
  end

endmodule

// File: rtl/sequence_checker.sv
// Checks debounced player key presses against the stored LED sequence.
//   clk, reset : system clock, asynchronous active-high reset
//   on_off     : enable; low returns the checker to IDLE
//   level      : last sequence index to check (0..9)
//   key_in     : raw player buttons, active-high
//   expected   : LED index read from memory at address count
//   count      : memory address of the next expected press
//   led_out    : echo of the accepted key while it is held
//   done/pass/fail : result flags, held until on_off drops
module sequence_checker
  import simon_pkg::*;
#(
  parameter int unsigned DEBOUNCE = 500_000,
  parameter int unsigned TIMEOUT  = 250_000_000
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 on_off,
  input  logic [CNT_W-1:0]     level,
  input  logic [NUM_KEYS-1:0]  key_in,
  input  logic [IDX_W-1:0]     expected,
  output logic [CNT_W-1:0]     count,
  output logic [LED_WIDTH-1:0] led_out,
  output logic                 done,
  output logic                 pass,
  output logic                 fail
);

  localparam int unsigned DB_W = $clog2(DEBOUNCE + 1);
  localparam int unsigned TO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [NUM_KEYS-1:0]  key_q;
  logic [NUM_KEYS-1:0]  stable;
  logic [DB_W-1:0]      deb_cnt;
  logic [DB_W-1:0]      deb_nxt;
  logic [TO_W-1:0]      to_q;
  logic [TO_W-1:0]      to_d;
  state_t               state_q;
  state_t               state_d;
  logic [CNT_W-1:0]     count_d;
  logic [LED_WIDTH-1:0] led_d;
  logic [IDX_W-1:0]     key_idx;
  logic                 key_valid;

  encoder_4_2 u_enc (
    .onehot (stable),
    .index  (key_idx),
    .valid  (key_valid)
  );

  // Run length of the current raw pattern, saturating at DEBOUNCE.
  always_comb begin
    deb_nxt = DB_W'(1);
    if (key_in == key_q) begin
      deb_nxt = (deb_cnt == DB_W'(DEBOUNCE)) ? deb_cnt : deb_cnt + DB_W'(1);
    end
  end

  // Debouncer; disabling the checker forces a fresh debounce of any held key.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      key_q   <= '0;
      deb_cnt <= '0;
      stable  <= '0;
    end else if (!on_off) begin
      key_q   <= key_in;
      deb_cnt <= '0;
      stable  <= '0;
    end else begin
      key_q   <= key_in;
      deb_cnt <= deb_nxt;
      if (deb_nxt == DB_W'(DEBOUNCE)) begin
        stable <= key_in;
      end
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d = state_q;
    count_d = count;
    led_d   = led_out;
    to_d    = to_q;
    case (state_q)
      IDLE: begin
        if (level <= CNT_W'(MAX_LEVEL)) begin
          state_d = WAIT_PRESS;
          count_d = '0;
          to_d    = '0;
        end
      end
      WAIT_PRESS: begin
        if (key_valid) begin
          if (key_idx == expected) begin
            led_d   = LED_WIDTH'(stable);
            state_d = WAIT_RELEASE;
          end else begin
            state_d = FAIL;
          end
        end else if (to_q == TO_W'(TIMEOUT - 1)) begin
          state_d = FAIL;
        end else begin
          to_d = to_q + TO_W'(1);
        end
      end
      WAIT_RELEASE: begin
        if (stable == '0) begin
          led_d = '0;
          // MAX_LEVEL guard keeps count in range even if level is changed mid-run
          if (count >= level || count == CNT_W'(MAX_LEVEL)) begin
            state_d = PASS;
          end else begin
            count_d = count + CNT_W'(1);
            to_d    = '0;
            state_d = WAIT_PRESS;
          end
        end
      end
      PASS, FAIL: state_d = state_q;
      default:    state_d = IDLE;
    endcase
    if (!on_off) begin
      state_d = IDLE;
      count_d = '0;
      led_d   = '0;
      to_d    = '0;
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      count   <= '0;
      led_out <= '0;
      to_q    <= '0;
      done    <= 1'b0;
      pass    <= 1'b0;
      fail    <= 1'b0;
    end else begin
      state_q <= state_d;
      count   <= count_d;
      led_out <= led_d;
      to_q    <= to_d;
      done    <= (state_d == PASS) || (state_d == FAIL);
      pass    <= (state_d == PASS);
      fail    <= (state_d == FAIL);
    end
  end

endmodule

// File: tb/tb_sequence_checker.sv
// Bench for sequence_checker with DEBOUNCE=4 and TIMEOUT=100.
module tb_sequence_checker;

  localparam int D = 4;
  localparam int T = 100;

  localparam int M_IDLE = 0;
  localparam int M_WP   = 1;
  localparam int M_WR   = 2;
  localparam int M_PASS = 3;
  localparam int M_FAIL = 4;

  logic       clk;
  logic       reset;
  logic       on_off;
  logic [3:0] level;
  logic [3:0] key_in;
  logic [1:0] expected;
  logic [3:0] count;
  logic [9:0] led_out;
  logic       done;
  logic       pass;
  logic       fail;

  logic [1:0] mem [16];
  assign expected = mem[count];

  int checks = 0;
  int errors = 0;

  // reference model state
  int m_st, m_count, m_led, m_wait, m_run, m_prev, m_stable;

  sequence_checker #(.DEBOUNCE(D), .TIMEOUT(T)) dut (
    .clk      (clk),
    .reset    (reset),
    .on_off   (on_off),
    .level    (level),
    .key_in   (key_in),
    .expected (expected),
    .count    (count),
    .led_out  (led_out),
    .done     (done),
    .pass     (pass),
    .fail     (fail)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  typedef struct {
    bit       on;
    int       lvl;
    logic [3:0] key;
    int       hold;
    int       m0;
    int       e_count;
    int       e_led;
    bit       e_done;
    bit       e_pass;
    bit       e_fail;
  } vec_t;

  vec_t vt[$];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int idx_of(input int k);
    int r = 0;
    for (int i = 0; i < 4; i++) if (k[i]) r = i;
    return r;
  endfunction

  task automatic model_reset();
    m_st = M_IDLE; m_count = 0; m_led = 0; m_wait = 0;
    m_run = 0; m_prev = 0; m_stable = 0;
  endtask

  // One clock edge of the behavioural reference, from the rules of the block.
  task automatic model_edge();
    int st_old;
    st_old = m_stable;
    if (reset) begin
      model_reset();
    end else if (!on_off) begin
      model_reset();
      m_prev = int'(key_in);
    end else begin
      if (int'(key_in) != m_prev) m_run = 1;
      else if (m_run < D) m_run++;
      m_prev = int'(key_in);
      if (m_run == D) m_stable = int'(key_in);
      case (m_st)
        M_IDLE: if (int'(level) <= 9) begin
          m_st = M_WP; m_count = 0; m_wait = 0;
        end
        M_WP: begin
          if ($countones(4'(st_old)) == 1) begin
            if (idx_of(st_old) == int'(mem[m_count])) begin
              m_led = st_old; m_st = M_WR;
            end else begin
              m_st = M_FAIL;
            end
          end else begin
            m_wait++;
            if (m_wait >= T) m_st = M_FAIL;
          end
        end
        M_WR: if (st_old == 0) begin
          m_led = 0;
          if (m_count == int'(level)) m_st = M_PASS;
          else begin m_count++; m_wait = 0; m_st = M_WP; end
        end
        default: ;
      endcase
    end
  endtask

  task automatic compare_model();
    chk("model_count", int'(count), m_count);
    chk("model_led", int'(led_out), m_led);
    chk("model_done", int'(done), (m_st == M_PASS || m_st == M_FAIL) ? 1 : 0);
    chk("model_pass", int'(pass), (m_st == M_PASS) ? 1 : 0);
    chk("model_fail", int'(fail), (m_st == M_FAIL) ? 1 : 0);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    compare_model();
  endtask

  task automatic hold_for(input int n);
    repeat (n) step();
  endtask

  initial begin
    int fired, n_edge, r, hold, cyc;

    reset = 1'b0; on_off = 1'b0; level = 4'd0; key_in = 4'd0;
    for (int i = 0; i < 16; i++) mem[i] = 2'd0;
    model_reset();

    // reset asserted before any clock edge
    #2 reset = 1'b1;
    #1;
    chk("reset_count", int'(count), 0);
    chk("reset_led", int'(led_out), 0);
    chk("reset_flags", int'({done, pass, fail}), 0);
    hold_for(2);
    reset = 1'b0;

    // full pass, then wrong key
    mem[1] = 2'd3; mem[2] = 2'd0;
    vt.push_back('{1'b0, 2, 4'b0000,  2, 1, 0, 0, 1'b0, 1'b0, 1'b0});
    vt.push_back('{1'b1, 2, 4'b0000,  3, 1, 0, 0, 1'b0, 1'b0, 1'b0});
    vt.push_back('{1'b1, 2, 4'b0010, 10, 1, 0, 2, 1'b0, 1'b0, 1'b0});
    vt.push_back('{1'b1, 2, 4'b0000, 10, 1, 1, 0, 1'b0, 1'b0, 1'b0});
    vt.push_back('{1'b1, 2, 4'b1000, 10, 1, 1, 8, 1'b0, 1'b0, 1'b0});
    vt.push_back('{1'b1, 2, 4'b0000, 10, 1, 2, 0, 1'b0, 1'b0, 1'b0});
    vt.push_back('{1'b1, 2, 4'b0001, 10, 1, 2, 1, 1'b0, 1'b0, 1'b0});
    vt.push_back('{1'b1, 2, 4'b0000, 10, 1, 2, 0, 1'b1, 1'b1, 1'b0});
    vt.push_back('{1'b1, 2, 4'b0100,  8, 1, 2, 0, 1'b1, 1'b1, 1'b0});
    vt.push_back('{1'b0, 2, 4'b0000,  1, 1, 0, 0, 1'b0, 1'b0, 1'b0});
    vt.push_back('{1'b1, 3, 4'b0000,  2, 2, 0, 0, 1'b0, 1'b0, 1'b0});
    vt.push_back('{1'b1, 3, 4'b0001, 10, 2, 0, 0, 1'b1, 1'b0, 1'b1});
    vt.push_back('{1'b1, 3, 4'b0000, 10, 2, 0, 0, 1'b1, 1'b0, 1'b1});
    vt.push_back('{1'b0, 3, 4'b0000,  1, 2, 0, 0, 1'b0, 1'b0, 1'b0});

    foreach (vt[i]) begin
      on_off = vt[i].on; level = 4'(vt[i].lvl); key_in = vt[i].key;
      mem[0] = 2'(vt[i].m0);
      hold_for(vt[i].hold);
      chk($sformatf("row%0d_count", i), int'(count), vt[i].e_count);
      chk($sformatf("row%0d_led", i), int'(led_out), vt[i].e_led);
      chk($sformatf("row%0d_done", i), int'(done), int'(vt[i].e_done));
      chk($sformatf("row%0d_pass", i), int'(pass), int'(vt[i].e_pass));
      chk($sformatf("row%0d_fail", i), int'(fail), int'(vt[i].e_fail));
    end

    // timeout with a too-short press in the middle
    on_off = 1'b0; level = 4'd0; key_in = 4'd0; hold_for(2);
    on_off = 1'b1; fired = 0; n_edge = 0;
    for (int i = 1; i <= 150 && fired == 0; i++) begin
      if (i == 50) key_in = 4'b0001;
      if (i == 53) key_in = 4'b0000;
      step();
      if (fail) begin fired = 1; n_edge = i; end
    end
    chk("timeout_fired", fired, 1);
    chk("timeout_edges", n_edge, 101);

    // invalid multi-key pattern is not a press
    on_off = 1'b0; hold_for(2);
    on_off = 1'b1; level = 4'd1; mem[0] = 2'd1; key_in = 4'b0110;
    hold_for(20);
    chk("multikey_led", int'(led_out), 0);
    chk("multikey_flags", int'({done, pass, fail}), 0);

    // out-of-range level keeps the checker idle (no timeout)
    on_off = 1'b0; key_in = 4'd0; hold_for(2);
    level = 4'd12; on_off = 1'b1;
    hold_for(120);
    chk("badlevel_flags", int'({done, pass, fail}), 0);
    chk("badlevel_count", int'(count), 0);

    // abort at count=1
    on_off = 1'b0; hold_for(2);
    level = 4'd2; mem[0] = 2'd1; mem[1] = 2'd3; on_off = 1'b1; hold_for(2);
    key_in = 4'b0010; hold_for(8);
    key_in = 4'b0000; hold_for(8);
    chk("abort_count_before", int'(count), 1);
    key_in = 4'b1000; hold_for(3);
    on_off = 1'b0; step();
    chk("abort_count_after", int'(count), 0);
    chk("abort_flags", int'({done, pass, fail}), 0);

    // async reset while a key is echoed
    on_off = 1'b1; key_in = 4'b0000; hold_for(2);
    key_in = 4'b0010; hold_for(8);
    chk("pre_reset_led", int'(led_out), 2);
    #2 reset = 1'b1;
    #1;
    chk("async_reset_led", int'(led_out), 0);
    chk("async_reset_flags", int'({done, pass, fail}), 0);
    model_reset();
    step();
    reset = 1'b0; on_off = 1'b0; key_in = 4'd0; step();

    // randomized run against the reference model
    for (int i = 0; i < 16; i++) mem[i] = 2'($urandom_range(0, 3));
    cyc = 0;
    while (cyc < 4000) begin
      r = $urandom_range(0, 99);
      if (r < 3) begin
        on_off = 1'b0;
        level = 4'($urandom_range(0, 11));
      end else begin
        on_off = 1'b1;
      end
      r = $urandom_range(0, 99);
      if (r < 45)      key_in = 4'(1) << mem[m_count];
      else if (r < 80) key_in = 4'd0;
      else             key_in = 4'($urandom_range(0, 15));
      hold = $urandom_range(1, 12);
      hold_for(hold);
      cyc += hold;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
